// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch packet layout and queue limits.
package pipe_pkg;

  localparam int IDQ_MAX_DEPTH = 16;

  // Packed payload layout, LSB first: taken | target | inst | pc_p4 | pc
  function automatic int fetch_pkt_w(input int xlen, input int ilen);
    return 2 * xlen + ilen + xlen + 1;
  endfunction

  function automatic int off_taken();
    return 0;
  endfunction

  function automatic int off_target();
    return 1;
  endfunction

  function automatic int off_inst(input int xlen);
    return xlen + 1;
  endfunction

  function automatic int off_pc_p4(input int xlen, input int ilen);
    return xlen + ilen + 1;
  endfunction

  function automatic int off_pc(input int xlen, input int ilen);
    return 2 * xlen + ilen + 1;
  endfunction

  localparam int FETCH_PKT_W = fetch_pkt_w(32, 32);

endpackage

// File: rtl/id_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch side, decode side, flush and occupancy.
interface id_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 2
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   pc_p4_i;
  logic [ILEN-1:0]   inst_i;
  logic              bp_pred_taken_i;
  logic [XLEN-1:0]   bp_pred_target_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   pc_p4_o;
  logic [ILEN-1:0]   inst_o;
  logic              bp_pred_taken_o;
  logic [XLEN-1:0]   bp_pred_target_o;
  logic [CNT_W-1:0]  count_o;

  // The queue itself
  modport slave (
    input  flush_i, in_valid_i, pc_i, pc_p4_i, inst_i, bp_pred_taken_i,
           bp_pred_target_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, pc_p4_o, inst_o, bp_pred_taken_o,
           bp_pred_target_o, count_o
  );

  // Whoever drives fetch/decode/flush
  modport master (
    output flush_i, in_valid_i, pc_i, pc_p4_i, inst_i, bp_pred_taken_i,
           bp_pred_target_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, pc_p4_o, inst_o, bp_pred_taken_o,
           bp_pred_target_o, count_o
  );
endinterface

// File: rtl/id_fetch_queue_mem.sv
// Packet storage: one synchronous write port at tail, one asynchronous read port at head.
module id_fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 129,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed packet; contents are never reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO with valid/ready on both sides and single-cycle flush.
module id_fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  id_fetch_queue_if.slave bus
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PKT_W   = fetch_pkt_w(XLEN, ILEN);
  localparam int O_TAKEN = off_taken();
  localparam int O_TGT   = off_target();
  localparam int O_INST  = off_inst(XLEN);
  localparam int O_PCP4  = off_pc_p4(XLEN, ILEN);
  localparam int O_PC    = off_pc(XLEN, ILEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             not_full;
  logic             push;
  logic             pop;
  logic [PKT_W-1:0] wdata;
  logic [PKT_W-1:0] rdata;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready/valid come only from state, so no combinational path between the two sides
  assign not_empty = (count != '0);
  assign not_full  = (count < FULL_CNT);
  assign push      = bus.in_valid_i && not_full && !bus.flush_i;
  assign pop       = not_empty && bus.out_ready_i && !bus.flush_i;

  assign wdata = {bus.pc_i, bus.pc_p4_i, bus.inst_i, bus.bp_pred_target_i, bus.bp_pred_taken_i};

  // Pointer and occupancy update; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  id_fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  // Empty queue presents an all-zero bubble, same as a cleared pipeline register
  assign bus.in_ready_o       = not_full;
  assign bus.out_valid_o      = not_empty;
  assign bus.count_o          = count;
  assign bus.pc_o             = not_empty ? rdata[O_PC +: XLEN]   : '0;
  assign bus.pc_p4_o          = not_empty ? rdata[O_PCP4 +: XLEN] : '0;
  assign bus.inst_o           = not_empty ? rdata[O_INST +: ILEN] : '0;
  assign bus.bp_pred_target_o = not_empty ? rdata[O_TGT +: XLEN]  : '0;
  assign bus.bp_pred_taken_o  = not_empty ? rdata[O_TAKEN]        : 1'b0;

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: a DEPTH=2 and a DEPTH=3 instance share stimulus, a model tracks the selected one.
module tb_id_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        taken = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] target = '0;
  bit          sel = 1'b0;

  logic        o_valid, o_ready, o_taken;
  logic [31:0] o_pc, o_pc_p4, o_inst, o_target;
  logic [1:0]  o_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic [31:0] inst;
    logic [31:0] target;
    logic        taken;
  } pkt_t;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          rdy;
    bit          fl;
    int          exp_cnt;
  } vec_t;

  pkt_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   mcount = 0;
  int   mdepth = 2;
  int   pops = 0;
  bit   seen_bp = 1'b0;
  bit   seen_flushed = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] make_inst(input logic [31:0] p);
    return p ^ 32'hDEAD_0013;
  endfunction

  id_fetch_queue_if #(.XLEN(32), .ILEN(32), .CNT_W(2)) bus_a ();
  id_fetch_queue_if #(.XLEN(32), .ILEN(32), .CNT_W(2)) bus_b ();

  assign bus_a.flush_i          = flush;
  assign bus_a.in_valid_i       = in_valid;
  assign bus_a.pc_i             = pc;
  assign bus_a.pc_p4_i          = pc + 32'd4;
  assign bus_a.inst_i           = make_inst(pc);
  assign bus_a.bp_pred_taken_i  = taken;
  assign bus_a.bp_pred_target_i = target;
  assign bus_a.out_ready_i      = out_ready;

  assign bus_b.flush_i          = flush;
  assign bus_b.in_valid_i       = in_valid;
  assign bus_b.pc_i             = pc;
  assign bus_b.pc_p4_i          = pc + 32'd4;
  assign bus_b.inst_i           = make_inst(pc);
  assign bus_b.bp_pred_taken_i  = taken;
  assign bus_b.bp_pred_target_i = target;
  assign bus_b.out_ready_i      = out_ready;

  id_fetch_queue #(.DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  id_fetch_queue #(.DEPTH(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Route the instance under test to the checking signals
  always_comb begin
    o_valid  = sel ? bus_b.out_valid_o      : bus_a.out_valid_o;
    o_ready  = sel ? bus_b.in_ready_o       : bus_a.in_ready_o;
    o_pc     = sel ? bus_b.pc_o             : bus_a.pc_o;
    o_pc_p4  = sel ? bus_b.pc_p4_o          : bus_a.pc_p4_o;
    o_inst   = sel ? bus_b.inst_o           : bus_a.inst_o;
    o_target = sel ? bus_b.bp_pred_target_o : bus_a.bp_pred_target_o;
    o_taken  = sel ? bus_b.bp_pred_taken_o  : bus_a.bp_pred_taken_o;
    o_count  = sel ? bus_b.count_o          : bus_a.count_o;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    taken = 1'b0;
    pc = '0;
    target = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mcount = 0;
    sb.delete();
  endtask

  // Drive one cycle at negedge, check state-derived outputs against the model, then advance the model
  task automatic apply_stimulus(input bit v, input logic [31:0] p, input bit tk, input logic [31:0] tg,
                                input bit rdy, input bit fl, output bit accepted);
    pkt_t pk;
    bit   popped;
    in_valid = v;
    pc = p;
    taken = tk;
    target = tg;
    out_ready = rdy;
    flush = fl;
    #1;
    check_output("out_valid", {31'd0, o_valid}, (mcount != 0) ? 32'd1 : 32'd0);
    check_output("in_ready", {31'd0, o_ready}, (mcount < mdepth) ? 32'd1 : 32'd0);
    check_output("count", {30'd0, o_count}, mcount);
    if (o_valid && o_pc == 32'h200) seen_flushed = 1'b1;
    if (mcount != 0) begin
      check_output("head_pc", o_pc, sb[0].pc);
      check_output("head_pc_p4", o_pc_p4, sb[0].pc_p4);
      check_output("head_inst", o_inst, sb[0].inst);
      check_output("head_target", o_target, sb[0].target);
      check_output("head_taken", {31'd0, o_taken}, {31'd0, sb[0].taken});
    end else begin
      check_output("bubble_pc", o_pc, 32'd0);
      check_output("bubble_inst", o_inst, 32'd0);
      check_output("bubble_target", o_target, 32'd0);
    end
    accepted = v && (mcount < mdepth) && !fl;
    popped   = (mcount != 0) && rdy && !fl;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (popped) begin
        pk = sb.pop_front();
        pops++;
        if (pk.taken && pk.target == 32'h400) seen_bp = 1'b1;
      end
      if (accepted) begin
        pk.pc = p;
        pk.pc_p4 = p + 32'd4;
        pk.inst = make_inst(p);
        pk.target = tg;
        pk.taken = tk;
        sb.push_back(pk);
      end
      mcount = mcount + (accepted ? 1 : 0) - (popped ? 1 : 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int sent;

    // DEPTH=2: back-pressure, refusal when full, ordered drain, streaming, flush
    vecs.push_back(vec_t'{1'b0, 32'h000, 1'b0, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 32'h100, 1'b0, 1'b0, 1});
    vecs.push_back(vec_t'{1'b1, 32'h104, 1'b0, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 32'h108, 1'b0, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 32'h000, 1'b1, 1'b0, 1});
    vecs.push_back(vec_t'{1'b0, 32'h000, 1'b1, 1'b0, 0});
    for (int i = 0; i < 6; i++) vecs.push_back(vec_t'{1'b1, 32'(4 * i), 1'b1, 1'b0, 1});
    vecs.push_back(vec_t'{1'b0, 32'h000, 1'b1, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 32'h300, 1'b0, 1'b0, 1});
    vecs.push_back(vec_t'{1'b1, 32'h304, 1'b0, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 32'h200, 1'b1, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 32'h000, 1'b0, 1'b0, 0});

    sel = 1'b0;
    mdepth = 2;
    do_reset();
    pops = 0;
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].v, vecs[i].pc, 1'b0, 32'd0, vecs[i].rdy, vecs[i].fl, acc);
      check_output($sformatf("vec%0d_count", i), {30'd0, o_count}, vecs[i].exp_cnt);
    end
    check_output("depth2_pops", pops, 32'd8);
    check_output("flushed_pkt_seen", {31'd0, seen_flushed}, 32'd0);

    // DEPTH=3: seven packets through the wrap, the fifth carries a predicted-taken target
    sel = 1'b1;
    mdepth = 3;
    do_reset();
    pops = 0;
    sent = 0;
    for (int cyc = 0; cyc < 40 && pops < 7; cyc++) begin
      apply_stimulus(sent < 7, 32'h500 + 32'(4 * sent), sent == 4, (sent == 4) ? 32'h400 : 32'd0,
                     cyc[0], 1'b0, acc);
      if (acc) sent++;
    end
    check_output("depth3_pops", pops, 32'd7);
    check_output("depth3_bp_carried", {31'd0, seen_bp}, 32'd1);

    // Asynchronous reset mid-cycle at count=2
    sel = 1'b0;
    mdepth = 2;
    do_reset();
    apply_stimulus(1'b1, 32'h700, 1'b0, 32'd0, 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, 32'h704, 1'b0, 32'd0, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", {31'd0, o_valid}, 32'd0);
    check_output("async_rst_ready", {31'd0, o_ready}, 32'd1);
    check_output("async_rst_count", {30'd0, o_count}, 32'd0);
    check_output("async_rst_pc", o_pc, 32'd0);
    check_output("async_rst_inst", o_inst, 32'd0);
    mcount = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_fetch_queue.md
Name: id_fetch_queue

Overview:
Parametrised IF/ID stage. It replaces the single-entry enable/clear fetch register with a DEPTH-entry FIFO between fetch and decode, using a valid/ready handshake on both sides. Each entry carries one fetch packet: pc valid, pc, pc+4, instruction, branch-predictor taken flag and predicted target. Flush (branch mispredict or trap) empties the queue in one cycle.

Parameters:
- DEPTH, 2, number of packet entries; legal values are 1 to 16, and powers of two are not required.
- XLEN, 32, width of pc, pc+4 and bp target.
- ILEN, 32, instruction width.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries; dominates every other input in the same cycle.
- in_valid_i  in  1  fetch offers a packet.
- in_ready_o  out  1  queue can accept a packet.
- pc_i  in  XLEN  fetch pc.
- pc_p4_i  in  XLEN  pc+4.
- inst_i  in  ILEN  fetched instruction.
- bp_pred_taken_i  in  1  predictor taken flag.
- bp_pred_target_i  in  XLEN  predicted target.
- out_valid_o  out  1  head entry is valid.
- out_ready_i  in  1  decode consumes the head this cycle.
- pc_o, pc_p4_o  out  XLEN  head packet pc and pc+4.
- inst_o  out  ILEN  head instruction.
- bp_pred_taken_o  out  1  head predictor taken flag.
- bp_pred_target_o  out  XLEN  head predicted target.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Head pointer, tail pointer and count go to 0.
  - out_valid_o=0, in_ready_o=1, count_o=0.
  - All payload outputs are 0.
  - Storage contents need not be reset.
- Handshakes:
  - Push occurs when in_valid_i and in_ready_o are both 1.
  - Pop occurs when out_valid_o and out_ready_i are both 1.
- in_ready_o = (count < DEPTH).
  - It depends only on state, so there is no combinational path from out_ready_i.
  - A full queue refuses a push even if a pop happens in the same cycle.
- out_valid_o = (count != 0). It depends only on state.
- Latency:
  - A packet pushed at edge N is visible on the outputs after edge N; minimum latency is 1 cycle.
  - There is no combinational input-to-output bypass.
- Payload outputs:
  - Driven from the head entry when out_valid_o=1.
  - Forced to 0 when out_valid_o=0, so decode sees a bubble identical to a cleared register.
- Pointers:
  - Tail advances on push and head advances on pop.
  - Each wraps from DEPTH-1 to 0, so non-power-of-two DEPTH is supported.
- Count update per cycle:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together (legal when 0 < count < DEPTH): unchanged.
- Empty with in_valid_i=1: the push is accepted and out_valid_o goes to 1 next cycle. There is no pop in the same cycle.
- Flush:
  - On the next edge, head, tail and count go to 0 and out_valid_o goes to 0.
  - Any push in the flush cycle is dropped; a pop in the flush cycle has no effect beyond the flush.
  - in_ready_o remains as computed from state during the flush cycle; fetch must discard its own packet on flush.
- Back-pressure: with out_ready_i=0, all head outputs are held stable while out_valid_o=1.
- Reset mid-operation: asynchronous clear as above; in-flight packets are lost.
- Pipeline-valid qualification: packets with pc_valid=0 are not pushed. Fetch presents them with in_valid_i=0.
- DEPTH=1: behaves as a half-throughput register. It alternates push and pop and can never push and pop in the same cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - FETCH_PKT_W = 2*XLEN + ILEN + XLEN + 1, the packed payload width.
  - Field offset constants for packing and unpacking the payload.
  - The constant IDQ_MAX_DEPTH=16.
- Sub-module id_fetch_queue_mem holds the storage:
  - DEPTH x FETCH_PKT_W register array.
  - One synchronous write port (tail, write enable) and one asynchronous read port (head).
  - No reset on the array.
- Top level holds the pointers, count, handshake, flush logic and output zero-masking.

Test Plan:
- Reset then idle: out_valid_o=0, in_ready_o=1, count_o=0, pc_o=0, inst_o=0.
- DEPTH=2: push pc 0x100 then 0x104 with out_ready_i=0 -> count_o=2, in_ready_o=0, pc_o=0x100 held. A third push of 0x108 is refused. Raising out_ready_i pops 0x100 then 0x104 in order; pc_p4_o=0x104 then 0x108.
- Continuous streaming, DEPTH=2, in_valid_i=out_ready_i=1, pc incrementing by 4 from 0x0 -> one packet per cycle after a 1-cycle fill, and count_o stays at 1.
- Flush at count=2 together with a push of 0x200 -> next cycle out_valid_o=0, count_o=0. 0x200 never appears on pc_o.
- DEPTH=3 wrap: push/pop 7 packets interleaved, with bp_pred_taken_i=1 and bp_pred_target_i=0x400 on the 5th -> outputs match in order, and the 5th carries taken=1 and target 0x400 through the pointer wrap.
- Assert rst_n=0 asynchronously mid-cycle at count=2 -> outputs go to 0 immediately, without waiting for clk.
